// File: rtl/mulq_pkg.sv
// rtl/mulq_pkg.sv - shared types and defaults for the multiplier issue queue
package mulq_pkg;

    localparam int OP_W            = 32;
    localparam int PROD_W          = 64;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_MUL_LATENCY = 34;
    localparam int DEF_ON_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } mulq_state_t;

endpackage

// File: rtl/mulq_fifo.sv
// rtl/mulq_fifo.sv - operand-pair FIFO with wrapping pointers and occupancy count
module mulq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_issue_queue.sv
// rtl/mult_issue_queue.sv - queues operand pairs and issues them one at a time to a multi-cycle multiplier (optional res_ovf via MULQ_OVERFLOW_FLAG_EN)
module mult_issue_queue
    import mulq_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int ON_CYCLES   = DEF_ON_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_on,
    input  logic [PROD_W-1:0] mul_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_data
`ifdef MULQ_OVERFLOW_FLAG_EN
    ,
    output logic              res_ovf
`endif
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [8:0]  LAT_C   = 9'(MUL_LATENCY);
    localparam logic [8:0]  ON_LAST = 9'(ON_CYCLES - 1);

    mulq_state_t           state;
    mulq_state_t           state_nxt;
    logic [8:0]            timer;
    logic                  start;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [2*OP_W-1:0]     fifo_head;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = capture && !fifo_empty;
    assign mul_on   = (state == ISSUE);

    mulq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*OP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data ({in_a, in_b}),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state decode; timer counts cycles since the first mul_on cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_nxt = ISSUE;
                    start     = 1'b1;
                end
            end
            ISSUE: begin
                if (timer == ON_LAST) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (timer >= LAT_C) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, timer, operand latch and result register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                timer          <= '0;
                {mul_a, mul_b} <= fifo_head;
            end else if (state == ISSUE || state == WAIT) begin
                timer <= timer + 9'd1;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= mul_out;
            end else if (state == HOLD && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MULQ_OVERFLOW_FLAG_EN
    // Overflow flag is captured alongside the product it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_ovf <= 1'b0;
        end else if (capture) begin
            res_ovf <= (mul_out[63:32] != '0);
        end
    end
`endif

endmodule

// File: tb/tb_mult_issue_queue.sv
// tb/tb_mult_issue_queue.sv - scoreboard bench with behavioural multiplier for mult_issue_queue
module tb_mult_issue_queue;

    localparam int DEPTH = 4;
    localparam int LAT   = 34;
    localparam int ONC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_on;
    logic [63:0] mul_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
`ifdef MULQ_OVERFLOW_FLAG_EN
    logic        res_ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_issue_queue #(
        .DEPTH       (DEPTH),
        .MUL_LATENCY (LAT),
        .ON_CYCLES   (ONC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_on    (mul_on),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef MULQ_OVERFLOW_FLAG_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t       opq[$];
    logic [63:0] res_log[$];
    int          results  = 0;
    bit          active   = 0;
    int          mcnt     = 0;
    int          on_cnt   = 0;
    logic [31:0] ma = '0;
    logic [31:0] mb = '0;
    bit          res_seen = 0;
    logic [63:0] held = '0;
    logic [63:0] expv;
    bit          rand_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard plus a multiplier that is only correct LAT cycles after start.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                opq.delete();
                active   = 0;
                res_seen = 0;
                on_cnt   = 0;
                mcnt     = 0;
            end else begin
                if (active) mcnt++;
                if (res_valid) begin
                    if (!res_seen) begin
                        check("result_expected", 64'(opq.size() != 0), 64'd1);
                        if (opq.size() != 0) begin
                            expv = 64'(opq[0].a) * 64'(opq[0].b);
                            check("res_data", res_data, expv);
                            check("res_latency", 64'(mcnt), 64'(LAT + 1));
                            check("on_cycles", 64'(on_cnt), 64'(ONC));
`ifdef MULQ_OVERFLOW_FLAG_EN
                            check("res_ovf", 64'(res_ovf), 64'(expv[63:32] != 0));
`endif
                        end
                        held     = res_data;
                        res_seen = 1;
                        active   = 0;
                    end else begin
                        check("res_stable", res_data, held);
                        check("hold_mul_on", 64'(mul_on), 64'd0);
                    end
                    if (res_ready) begin
                        if (opq.size() != 0) void'(opq.pop_front());
                        res_log.push_back(res_data);
                        res_seen = 0;
                        results++;
                    end
                end
                if (mul_on) begin
                    if (!active) begin
                        check("issue_nonempty", 64'(opq.size() != 0), 64'd1);
                        if (opq.size() != 0) begin
                            check("issue_a", 64'(mul_a), 64'(opq[0].a));
                            check("issue_b", 64'(mul_b), 64'(opq[0].b));
                        end
                        active = 1;
                        mcnt   = 0;
                        on_cnt = 1;
                        ma     = mul_a;
                        mb     = mul_b;
                    end else begin
                        check("mul_on_contig", 64'(mcnt), 64'(on_cnt));
                        on_cnt++;
                    end
                end
                if (active) begin
                    check("mul_a_hold", 64'(mul_a), 64'(ma));
                    check("mul_b_hold", 64'(mul_b), 64'(mb));
                end
                if (in_valid && in_ready) begin
                    opq.push_back('{a: in_a, b: in_b});
                end
            end
            mul_out = (active && mcnt >= LAT) ? 64'(ma) * 64'(mb) : 64'hA5A5_5A5A_DEAD_BEEF;
        end
    end

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, output int waited);
        waited   = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("push_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int limit);
        int n = 0;
        while (results < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("results_count", 64'(results), 64'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        int base;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_mul_on", 64'(mul_on), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pair
        res_ready = 1'b1;
        push_pair(32'd2, 32'd23, w);
        wait_results(1, 200);
        check("t1_data", res_log[res_log.size()-1], 64'd46);

        // Back-to-back, including the largest product
        push_pair(32'd125, 32'd25, w);
        push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        wait_results(3, 400);
        check("t2_first", res_log[res_log.size()-2], 64'd3125);
        check("t2_second", res_log[res_log.size()-1], 64'hFFFF_FFFE_0000_0001);

        // Fill the queue with the consumer stalled
        res_ready = 1'b0;
        base = results;
        push_pair(32'd7, 32'd9, w);
        push_pair(32'd11, 32'd13, w);
        push_pair(32'd17, 32'd19, w);
        push_pair(32'd23, 32'd29, w);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("first_in_wait", 64'(active), 64'd1);
        push_pair(32'd31, 32'd37, w);
        check("fifth_waited", 64'(w > 0), 64'd1);
        check("fifth_after_pop", 64'(res_valid), 64'd1);
        repeat (20) @(negedge clk);
        check("hold_valid", 64'(res_valid), 64'd1);
        check("hold_data", res_data, 64'd63);
        check("hold_no_issue", 64'(mul_on), 64'd0);
        res_ready = 1'b1;
        wait_results(base + 5, 1000);

        // Reset mid-WAIT flushes everything queued
        push_pair(32'd3, 32'd4, w);
        push_pair(32'd5, 32'd6, w);
        push_pair(32'd8, 32'd9, w);
        w = 0;
        while (!(active && mcnt >= 5) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reached_wait", 64'(active), 64'd1);
        base = results;
        rst = 1'b1;
        @(negedge clk);
        check("flush_mul_on", 64'(mul_on), 64'd0);
        check("flush_mul_a", 64'(mul_a), 64'd0);
        check("flush_mul_b", 64'(mul_b), 64'd0);
        check("flush_res_valid", 64'(res_valid), 64'd0);
        check("flush_res_data", res_data, 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("flush_no_result", 64'(results), 64'(base));

        // Zero operand
        push_pair(32'd0, 32'd12345, w);
        wait_results(base + 1, 200);
        check("zero_data", res_log[res_log.size()-1], 64'd0);

        // Randomised traffic with random back-pressure
        base = results;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    case ($urandom_range(0, 7))
                        0:       ra = 32'd0;
                        1:       ra = 32'hFFFF_FFFF;
                        default: ra = $urandom;
                    endcase
                    case ($urandom_range(0, 7))
                        0:       rb = 32'd0;
                        1:       rb = 32'hFFFF_FFFF;
                        default: rb = $urandom;
                    endcase
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push_pair(ra, rb, w);
                end
                wait_results(base + 1000, 3000);
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_issue_queue.md
MULT_ISSUE_QUEUE -- requirements
Module: mult_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, operand-pair FIFO entries, power of two, 2..16.
REQ-002 Parameter MUL_LATENCY, default 34, cycles from first mul_on cycle to valid mul_out, range 2..255.
REQ-003 Parameter ON_CYCLES, default 2, cycles mul_on is held high per issue, range 1..4.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  queue can accept a pair this cycle.
REQ-008 in_a, in_b  input  32 each  operands, unsigned.
REQ-009 mul_a, mul_b  output  32 each  operands driven to the shift-and-add multiplier.
REQ-010 mul_on  output  1  multiplier start strobe.
REQ-011 mul_out  input  64  multiplier product.
REQ-012 res_valid  output  1  product available.
REQ-013 res_ready  input  1  downstream accepts product.
REQ-014 res_data  output  64  captured product.

Function
REQ-015 Push occurs when in_valid && in_ready; in_ready = (count < DEPTH), combinational from registered count.
REQ-016 FSM states IDLE, ISSUE, WAIT, HOLD; IDLE->ISSUE when count != 0.
REQ-017 ISSUE: mul_a/mul_b = FIFO head, mul_on = 1 for exactly ON_CYCLES cycles, then ->WAIT.
REQ-018 mul_a/mul_b hold the head pair, unchanged, throughout ISSUE and WAIT; outside those states they hold their last value (0 after reset).
REQ-019 WAIT: counter expires MUL_LATENCY cycles after the first mul_on cycle; on that edge res_data <= mul_out, res_valid <= 1, FIFO head popped, ->HOLD.
REQ-020 HOLD: res_valid and res_data stable until res_valid && res_ready; on that edge res_valid <= 0, ->IDLE.
REQ-021 Simultaneous push and pop in one cycle: both occur, count unchanged; push into full queue never occurs (in_ready low).
REQ-022 FIFO pointers wrap modulo DEPTH; order strictly first-in first-out.
REQ-023 Only one multiplication outstanding at any time; mul_on never asserted outside ISSUE.
REQ-024 Products are full 64-bit unsigned, no truncation.

Reset
REQ-025 rst in any state, including mid-ISSUE or mid-WAIT: state <= IDLE, count/pointers <= 0, mul_on <= 0, mul_a/mul_b <= 0, res_valid <= 0, res_data <= 0, timers <= 0; in-flight product discarded.
REQ-026 rst has priority over push, pop and capture in the same cycle.

Configuration
REQ-027 Macro MULQ_OVERFLOW_FLAG_EN defined: extra output res_ovf (1 bit) = registered (mul_out[63:32] != 0), captured with res_data, reset 0.
REQ-028 Macro undefined: res_ovf port and logic absent; all other behaviour identical.

Structure
REQ-029 Shared package mulq_pkg holds the FSM state enum, operand/product width constants (32, 64), and default DEPTH/MUL_LATENCY/ON_CYCLES.
REQ-030 FIFO storage and pointers in sub-module mulq_fifo (push/pop/full/empty/count); FSM and timers in the top.

Verification
REQ-031 Reset, push (2,23), res_ready=1 -> mul_on high 2 cycles, res_valid after 34+ cycles, res_data = 46.
REQ-032 Push (125,25) then (0xFFFFFFFF,0xFFFFFFFF) back-to-back -> results 3125 then 0xFFFFFFFE00000001 in order; res_ovf 0 then 1 when macro defined.
REQ-033 Push 5 pairs with res_ready=0 -> in_ready low after 4 accepted while first is in WAIT; 5th accepted only after first pop.
REQ-034 res_ready held 0 for 20 cycles in HOLD -> res_valid/res_data stable, mul_on stays 0, no second issue until handshake.
REQ-035 Assert rst during WAIT with 3 pairs queued -> next cycle all outputs 0, in_ready 1, no result ever emitted for flushed pairs.
REQ-036 Push (0,12345) -> res_data = 0; multiplier model checked against A*B for 1000 random pairs.
